// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus controller: contention policy,
// default geometry and the fixed source-index map.
package bus_pkg;

    typedef enum logic {
        BUS_STRICT,
        BUS_PRIORITY
    } bus_mode_e;

    localparam int unsigned BUS_WIDTH_DEF = 16;
    localparam int unsigned BUS_NSRC_DEF  = 4;

    localparam int unsigned SRC_PC     = 0;
    localparam int unsigned SRC_ALU    = 1;
    localparam int unsigned SRC_MARMUX = 2;
    localparam int unsigned SRC_MDR    = 3;

endpackage

// File: rtl/bus_gate_decode.sv
// Gate-vector classifier: exactly-one / none / several asserted, plus the
// lowest asserted index. Knows nothing about bus data width.
module bus_gate_decode #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned IW   = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] gate_i,
    output logic            onehot_o,
    output logic            zero_o,
    output logic            multi_o,
    output logic [IW-1:0]   lowest_o
);

    always_comb begin
        int unsigned ones;
        logic        found;
        ones     = 0;
        found    = 1'b0;
        lowest_o = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (gate_i[i]) begin
                ones = ones + 1;
                if (!found) begin
                    lowest_o = IW'(i);
                    found    = 1'b1;
                end
            end
        end
        onehot_o = (ones == 1);
        zero_o   = (ones == 0);
        multi_o  = (ones > 1);
    end

endmodule

// File: rtl/shared_bus_ctrl.sv
// N-source, W-bit datapath bus with a keeper register, selectable contention
// policy and sticky/saturating contention error reporting.
module shared_bus_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_WIDTH_DEF,
    parameter int unsigned NSRC  = BUS_NSRC_DEF,
    parameter bus_mode_e   MODE  = BUS_STRICT,
    parameter int unsigned ERRW  = 8
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic [NSRC-1:0]         gate,
    input  logic                    clr_err,
    output logic [WIDTH-1:0]        bus_out,
    output logic                    bus_driven,
    output logic                    contention,
    output logic                    err_sticky,
    output logic [ERRW-1:0]         err_count,
    output logic [$clog2(NSRC)-1:0] last_src
);

    localparam int unsigned IW = $clog2(NSRC);

    logic             dec_onehot;
    logic             dec_zero;
    logic             dec_multi;
    logic [IW-1:0]    dec_lowest;
    logic [WIDTH-1:0] src_arr [NSRC];

    logic [WIDTH-1:0] keeper_q,     keeper_d;
    logic [IW-1:0]    last_src_q,   last_src_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERRW-1:0]  err_count_q,  err_count_d;

    bus_gate_decode #(
        .NSRC (NSRC),
        .IW   (IW)
    ) u_decode (
        .gate_i   (gate),
        .onehot_o (dec_onehot),
        .zero_o   (dec_zero),
        .multi_o  (dec_multi),
        .lowest_o (dec_lowest)
    );

    for (genvar i = 0; i < NSRC; i++) begin : g_unpack
        assign src_arr[i] = src_data[i*WIDTH +: WIDTH];
    end

    // With exactly one gate the lowest index is the only index, so a single
    // mux keyed on dec_lowest serves both policies.
    always_comb begin
        bus_driven = dec_onehot || ((MODE == BUS_PRIORITY) && !dec_zero);
        contention = dec_multi;
        bus_out    = bus_driven ? src_arr[dec_lowest] : keeper_q;
    end

    always_comb begin
        keeper_d     = keeper_q;
        last_src_d   = last_src_q;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        if (bus_driven) begin
            keeper_d   = bus_out;
            last_src_d = dec_lowest;
        end

        // Contention outranks a simultaneous clear: the clear is taken first,
        // then the current contention cycle is counted.
        if (contention) begin
            err_sticky_d = 1'b1;
            if (clr_err) begin
                err_count_d = ERRW'(1);
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + ERRW'(1);
            end
        end else if (clr_err) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            keeper_q     <= '0;
            last_src_q   <= '0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            keeper_q     <= keeper_d;
            last_src_q   <= last_src_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign last_src   = last_src_q;

endmodule

// File: doc/shared_bus_ctrl.md
# shared_bus_ctrl

Parametrised datapath bus controller. It replaces the fixed 4-source, 16-bit one-hot bus multiplexer with an N-source, W-bit bus. It adds a bus keeper that holds the last driven value, a contention policy, and sticky contention error reporting. It sits between the datapath gate signals (GatePC, GateALU, GateMARMUX, GateMDR, …) and every bus consumer (IR, MAR, MDR, register file, PC).

## Interface
Parameters:
- WIDTH, 16, bus data width in bits
- NSRC, 4, number of bus sources (≥2)
- MODE, BUS_STRICT, contention policy: BUS_STRICT = keeper value wins, BUS_PRIORITY = lowest-index gated source wins
- ERRW, 8, width of contention counter

Ports:
- Clk  input  1  system clock, rising edge
- Reset_n  input  1  asynchronous, active-low reset
- src_data  input  NSRC*WIDTH  packed source data, source i at bits [i*WIDTH +: WIDTH]
- gate  input  NSRC  per-source drive enable; index 0 = PC, 1 = ALU, 2 = MARMUX, 3 = MDR
- clr_err  input  1  synchronous clear of err_sticky and err_count
- bus_out  output  WIDTH  resolved bus value, combinational
- bus_driven  output  1  exactly one gate asserted, or MODE=BUS_PRIORITY with ≥1 gate asserted
- contention  output  1  two or more gates asserted this cycle, combinational
- err_sticky  output  1  registered, set by any contention cycle
- err_count  output  ERRW  registered saturating count of contention cycles
- last_src  output  $clog2(NSRC)  registered index of most recent winning source

## Operation
- Popcount of gate determines the case:
  - Zero gates: bus_out = keeper; bus_driven = 0.
  - One gate i: bus_out = src_data[i]; bus_driven = 1.
  - Two or more gates:
    - contention = 1.
    - BUS_STRICT: bus_out = keeper, bus_driven = 0.
    - BUS_PRIORITY: bus_out = source with lowest asserted index, bus_driven = 1.
- Keeper register: loads bus_out on every edge where bus_driven = 1, otherwise holds. bus_out never goes X.
- last_src: loads the winning index whenever the keeper loads.
- err_sticky: set on the edge following any contention cycle; cleared only by clr_err or reset.
- err_count: +1 per contention cycle; saturates at 2^ERRW−1 with no wrap.
- clr_err and contention on the same edge: contention wins. After that edge, err_sticky = 1 and err_count = 1.
- Reset (asynchronous, immediate on Reset_n low): keeper = 0, last_src = 0, err_sticky = 0, err_count = 0.
  - Therefore bus_out = 0 and bus_driven = combinational from gate.
  - Reset released mid-transfer: the first edge after release behaves as normal.

## Timing
- bus_out, bus_driven, contention: zero-latency combinational from gate/src_data. No register is in the data path to consumers.
- Keeper, last_src, err_sticky, err_count: update on the rising Clk edge; visible one cycle after the causing cycle.
- Gate change to idle: bus_out holds the value present on the last driven edge, with no glitch to 0.
- Back-to-back different sources in consecutive cycles: each cycle resolves independently.
- Reset assertion is asynchronous; deassertion is assumed synchronised upstream.

## Structure
- Package bus_pkg:
  - bus_mode_e enum {BUS_STRICT, BUS_PRIORITY}
  - default WIDTH/NSRC constants
  - source-index localparams SRC_PC=0, SRC_ALU=1, SRC_MARMUX=2, SRC_MDR=3
- Sub-module bus_gate_decode, purely combinational, parametrised on NSRC:
  - outputs: one-hot valid, zero, multi flags, lowest-set index
  - no knowledge of data width
- Top: decode instance, data mux, keeper/last_src registers, error logic.

## Test plan
- Reset, then gate=0001 with PC=16'h3000 → bus_out=3000 same cycle; next cycle gate=0000 → bus_out stays 3000, last_src=0.
- Sequence gate 0010 (ALU=16'hBEEF) then 1000 (MDR=16'h1234) → bus_out BEEF then 1234; last_src 1 then 3; contention never set.
- BUS_STRICT, keeper=16'h00AA, gate=0110 → bus_out=00AA, contention=1, bus_driven=0; next edge err_sticky=1, err_count=1, keeper unchanged.
- BUS_PRIORITY, gate=1100 (MARMUX=16'h4000, MDR=16'h5000) → bus_out=4000, contention=1; next edge keeper=4000, last_src=2, err_count=1.
- ERRW=2, five consecutive contention cycles → err_count 1,2,3,3,3. clr_err with gate=0000 → 0/0. clr_err with gate=0011 → sticky=1, count=1.
- Reset_n pulled low mid-cycle with keeper=16'hFFFF and err_count=2 → keeper, err_count, err_sticky, last_src reach 0 immediately, without waiting for Clk.
